// File: rtl/player_motion_ctrl.sv
// Per-frame player pose sequencer: rotate or move one step per frame_tick, with trig LUT handshake.
// Optional PLAYER_CLAMP_EN: clamp position to [MIN,MAX] per axis instead of wrapping modulo 1024.
module player_motion_ctrl #(
  parameter int unsigned X0          = 160,
  parameter int unsigned Y0          = 120,
  parameter int unsigned ANG0        = 0,
  parameter int unsigned ROT_STEP    = 1,
  parameter int unsigned SPEED_SHIFT = 2,
  parameter int unsigned XMIN        = 0,
  parameter int unsigned XMAX        = 639,
  parameter int unsigned YMIN        = 0,
  parameter int unsigned YMAX        = 479
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  output logic       trig_req,
  input  logic       trig_gnt,
  output logic [9:0] trig_ang,
  input  logic [9:0] trig_cos,
  input  logic [9:0] trig_sin,
  output logic [9:0] playerx,
  output logic [9:0] playery,
  output logic [9:0] playerang,
  output logic       busy,
  output logic       update_done,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, ROT, REQ, WAIT, MOVE, DONE} state_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [9:0] ROT_W = 10'(ROT_STEP);

  state_t      state;
  logic [7:0]  key_q;
  logic [9:0]  cos_q, sin_q;
  logic [9:0]  rot_ang;
  logic [9:0]  next_x, next_y;
  logic signed [9:0] dx, dy;
  logic        fwd;

  assign trig_ang = playerang;
  assign fwd      = (key_q == KEY_W);
  assign dx       = $signed(cos_q) >>> SPEED_SHIFT;
  assign dy       = $signed(sin_q) >>> SPEED_SHIFT;

  // Angle stays below 360 and ROT_STEP <= 359, so 10-bit intermediates never overflow.
  always_comb begin
    rot_ang = playerang;
    if (key_q == KEY_A)
      rot_ang = (playerang < ROT_W) ? playerang + 10'd360 - ROT_W : playerang - ROT_W;
    else
      rot_ang = (playerang + ROT_W > 10'd359) ? playerang + ROT_W - 10'd360 : playerang + ROT_W;
  end

`ifdef PLAYER_CLAMP_EN
  function automatic logic [9:0] bound(input logic [11:0] s, input int unsigned lo, input int unsigned hi);
    if ($signed(s) < $signed(12'(lo)))      return 10'(lo);
    else if ($signed(s) > $signed(12'(hi))) return 10'(hi);
    else                                    return s[9:0];
  endfunction

  logic [11:0] sum_x, sum_y;

  always_comb begin
    sum_x = '0;
    sum_y = '0;
    if (fwd) begin
      sum_x = {2'b00, playerx} + {{2{dx[9]}}, dx};
      sum_y = {2'b00, playery} + {{2{dy[9]}}, dy};
    end else begin
      sum_x = {2'b00, playerx} - {{2{dx[9]}}, dx};
      sum_y = {2'b00, playery} - {{2{dy[9]}}, dy};
    end
    next_x = bound(sum_x, XMIN, XMAX);
    next_y = bound(sum_y, YMIN, YMAX);
  end
`else
  // Low 10 bits of the 12-bit signed sum equal a plain modulo-1024 add/subtract.
  always_comb begin
    next_x = '0;
    next_y = '0;
    if (fwd) begin
      next_x = playerx + dx;
      next_y = playery + dy;
    end else begin
      next_x = playerx - dx;
      next_y = playery - dy;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      key_q       <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      playerx     <= 10'(X0);
      playery     <= 10'(Y0);
      playerang   <= 10'(ANG0);
      trig_req    <= 1'b0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      update_done <= 1'b0;
      if (frame_tick && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (frame_tick) begin
            key_q <= keycode;
            busy  <= 1'b1;
            case (keycode)
              KEY_A, KEY_D: state <= ROT;
              KEY_W, KEY_S: begin
                state    <= REQ;
                trig_req <= 1'b1;
              end
              default: begin
                state       <= DONE;
                update_done <= 1'b1;
              end
            endcase
          end
        end
        ROT: begin
          playerang   <= rot_ang;
          state       <= DONE;
          update_done <= 1'b1;
        end
        REQ: begin
          if (trig_gnt) begin
            trig_req <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          cos_q <= trig_cos;
          sin_q <= trig_sin;
          state <= MOVE;
        end
        MOVE: begin
          playerx     <= next_x;
          playery     <= next_y;
          state       <= DONE;
          update_done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
